// File: rtl/prbs_sync_checker.sv
// ---------------------------------------------------------------------------
// prbs_sync_checker
//   Self-synchronising PRBS checker for the slicer output bit stream.
//   The local LFSR is loaded from N_PRBS received bits (SEED). It is then
//   checked against the stream over one window (VERIFY). If that passes, the
//   LFSR free-runs and errors are counted (LOCKED). A window with too many
//   errors drops the checker back to SEED so it can re-acquire on its own.
//
// Ports
//   i_clock          clock
//   i_reset          asynchronous active-low reset
//   i_enable         bit-valid strobe; nothing advances while low
//   i_resync         synchronous restart: back to SEED, all counters cleared
//   i_clear_counters synchronous clear of error/bit counters only
//   i_bit            received bit
//   o_state          0=SEED 1=VERIFY 2=LOCKED
//   o_locked         high while LOCKED
//   o_err_count      errors seen while LOCKED (saturating)
//   o_bit_count      bits checked while LOCKED (saturating)
//   o_lock_loss_cnt  LOCKED->SEED transitions (saturating)
//   o_led            locked with no errors counted
// ---------------------------------------------------------------------------
module prbs_sync_checker #(
  parameter int N_PRBS      = 9,
  parameter int TAP         = 5,
  parameter int WIN_LOG2    = 7,
  parameter int LOCK_THRESH = 2,
  parameter int LOSS_THRESH = 8,
  parameter int NB_CNT      = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_resync,
  input  logic              i_clear_counters,
  input  logic              i_bit,
  output logic [1:0]        o_state,
  output logic              o_locked,
  output logic [NB_CNT-1:0] o_err_count,
  output logic [NB_CNT-1:0] o_bit_count,
  output logic [7:0]        o_lock_loss_cnt,
  output logic              o_led
);

  localparam int SEED_W = $clog2(N_PRBS);
  localparam int WERR_W = WIN_LOG2 + 1;

  localparam logic [SEED_W-1:0]   SEED_LAST  = SEED_W'(N_PRBS - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST   = {WIN_LOG2{1'b1}};
  localparam logic [WERR_W:0]     LOCK_LIMIT = (WERR_W + 1)'(LOCK_THRESH);
  localparam logic [WERR_W:0]     LOSS_LIMIT = (WERR_W + 1)'(LOSS_THRESH);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Saturating increment helpers
  function automatic logic [NB_CNT-1:0] sat_inc_cnt(input logic [NB_CNT-1:0] v, input logic inc);
    if (inc && (v != {NB_CNT{1'b1}})) begin
      sat_inc_cnt = v + NB_CNT'(1);
    end else begin
      sat_inc_cnt = v;
    end
  endfunction

  function automatic logic [7:0] sat_inc_8(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) begin
      sat_inc_8 = v + 8'd1;
    end else begin
      sat_inc_8 = v;
    end
  endfunction

  function automatic logic [WERR_W-1:0] sat_inc_werr(input logic [WERR_W-1:0] v, input logic inc);
    if (inc && (v != {WERR_W{1'b1}})) begin
      sat_inc_werr = v + WERR_W'(1);
    end else begin
      sat_inc_werr = v;
    end
  endfunction

  state_t              state_r;
  logic [N_PRBS-1:0]   lfsr_r;
  logic [SEED_W-1:0]   seed_cnt_r;
  logic [WIN_LOG2-1:0] win_cnt_r;
  logic [WERR_W-1:0]   win_err_r;
  logic [NB_CNT-1:0]   err_count_r;
  logic [NB_CNT-1:0]   bit_count_r;
  logic [7:0]          lock_loss_r;
  logic                locked_r;
  logic                led_r;

  state_t              state_nxt_s;
  logic [N_PRBS-1:0]   lfsr_nxt_s;
  logic [SEED_W-1:0]   seed_cnt_nxt_s;
  logic [WIN_LOG2-1:0] win_cnt_nxt_s;
  logic [WERR_W-1:0]   win_err_nxt_s;
  logic [NB_CNT-1:0]   err_count_nxt_s;
  logic [NB_CNT-1:0]   bit_count_nxt_s;
  logic [7:0]          lock_loss_nxt_s;
  logic                locked_nxt_s;
  logic                led_nxt_s;

  logic                pred_s;
  logic                err_s;
  logic                win_last_s;
  logic [WERR_W:0]     win_total_s;

  assign pred_s      = lfsr_r[N_PRBS-1] ^ lfsr_r[TAP-1];
  assign err_s       = i_bit ^ pred_s;
  assign win_last_s  = (win_cnt_r == WIN_LAST);
  // The bit on the last window cycle takes part in the window decision.
  assign win_total_s = {1'b0, win_err_r} + (WERR_W + 1)'(err_s);

  // Next-state computation for the acquisition FSM, LFSR and all counters
  always_comb begin
    state_nxt_s     = state_r;
    lfsr_nxt_s      = lfsr_r;
    seed_cnt_nxt_s  = seed_cnt_r;
    win_cnt_nxt_s   = win_cnt_r;
    win_err_nxt_s   = win_err_r;
    err_count_nxt_s = err_count_r;
    bit_count_nxt_s = bit_count_r;
    lock_loss_nxt_s = lock_loss_r;

    if (i_resync) begin
      state_nxt_s     = ST_SEED;
      seed_cnt_nxt_s  = '0;
      win_cnt_nxt_s   = '0;
      win_err_nxt_s   = '0;
      err_count_nxt_s = '0;
      bit_count_nxt_s = '0;
      lock_loss_nxt_s = 8'd0;
    end else begin
      if (i_clear_counters) begin
        err_count_nxt_s = '0;
        bit_count_nxt_s = '0;
      end else begin
        err_count_nxt_s = err_count_r;
        bit_count_nxt_s = bit_count_r;
      end

      if (i_enable) begin
        case (state_r)
          ST_SEED: begin
            // Received bits load the LFSR directly.
            lfsr_nxt_s = {lfsr_r[N_PRBS-2:0], i_bit};
            if (seed_cnt_r == SEED_LAST) begin
              state_nxt_s    = ST_VERIFY;
              seed_cnt_nxt_s = '0;
              win_cnt_nxt_s  = '0;
              win_err_nxt_s  = '0;
            end else begin
              seed_cnt_nxt_s = seed_cnt_r + SEED_W'(1);
            end
          end
          ST_VERIFY: begin
            // Flywheel: the received bit never enters the LFSR, so an
            // isolated error is counted exactly once.
            lfsr_nxt_s = {lfsr_r[N_PRBS-2:0], pred_s};
            if (win_last_s) begin
              if (win_total_s <= LOCK_LIMIT) begin
                state_nxt_s = ST_LOCKED;
              end else begin
                state_nxt_s = ST_SEED;
              end
              seed_cnt_nxt_s = '0;
              win_cnt_nxt_s  = '0;
              win_err_nxt_s  = '0;
            end else begin
              win_cnt_nxt_s = win_cnt_r + WIN_LOG2'(1);
              win_err_nxt_s = sat_inc_werr(win_err_r, err_s);
            end
          end
          ST_LOCKED: begin
            lfsr_nxt_s = {lfsr_r[N_PRBS-2:0], pred_s};
            if (!i_clear_counters) begin
              bit_count_nxt_s = sat_inc_cnt(bit_count_r, 1'b1);
              err_count_nxt_s = sat_inc_cnt(err_count_r, err_s);
            end else begin
              bit_count_nxt_s = '0;
              err_count_nxt_s = '0;
            end
            if (win_last_s) begin
              if (win_total_s > LOSS_LIMIT) begin
                state_nxt_s     = ST_SEED;
                seed_cnt_nxt_s  = '0;
                lock_loss_nxt_s = sat_inc_8(lock_loss_r, 1'b1);
              end else begin
                state_nxt_s = ST_LOCKED;
              end
              win_cnt_nxt_s = '0;
              win_err_nxt_s = '0;
            end else begin
              win_cnt_nxt_s = win_cnt_r + WIN_LOG2'(1);
              win_err_nxt_s = sat_inc_werr(win_err_r, err_s);
            end
          end
          default: begin
            state_nxt_s    = ST_SEED;
            seed_cnt_nxt_s = '0;
            win_cnt_nxt_s  = '0;
            win_err_nxt_s  = '0;
          end
        endcase
      end else begin
        lfsr_nxt_s = lfsr_r;
      end
    end

    locked_nxt_s = (state_nxt_s == ST_LOCKED);
    led_nxt_s    = locked_nxt_s && (err_count_nxt_s == '0);
  end

  // State and output registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r     <= ST_SEED;
      lfsr_r      <= '0;
      seed_cnt_r  <= '0;
      win_cnt_r   <= '0;
      win_err_r   <= '0;
      err_count_r <= '0;
      bit_count_r <= '0;
      lock_loss_r <= 8'd0;
      locked_r    <= 1'b0;
      led_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lfsr_r      <= lfsr_nxt_s;
      seed_cnt_r  <= seed_cnt_nxt_s;
      win_cnt_r   <= win_cnt_nxt_s;
      win_err_r   <= win_err_nxt_s;
      err_count_r <= err_count_nxt_s;
      bit_count_r <= bit_count_nxt_s;
      lock_loss_r <= lock_loss_nxt_s;
      locked_r    <= locked_nxt_s;
      led_r       <= led_nxt_s;
    end
  end

  assign o_state         = state_r;
  assign o_locked        = locked_r;
  assign o_err_count     = err_count_r;
  assign o_bit_count     = bit_count_r;
  assign o_lock_loss_cnt = lock_loss_r;
  assign o_led           = led_r;

endmodule

// File: tb/tb_prbs_sync_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs_sync_checker
//   Bench for prbs_sync_checker: a PRBS9 instance (defaults) and a PRBS7
//   instance sharing clock, reset and enable. Expected values are pushed to a
//   scoreboard queue as stimulus is driven and compared once the DUT responds.
// ---------------------------------------------------------------------------
module tb_prbs_sync_checker;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_resync;
  logic        i_clear_counters;
  logic        i_bit;
  logic        i_bit7;
  logic        resync7;
  logic        clear7;

  logic [1:0]  o_state;
  logic        o_locked;
  logic [31:0] o_err_count;
  logic [31:0] o_bit_count;
  logic [7:0]  o_lock_loss_cnt;
  logic        o_led;

  logic [1:0]  o_state7;
  logic        o_locked7;
  logic [31:0] o_err_count7;
  logic [31:0] o_bit_count7;
  logic [7:0]  o_lock_loss_cnt7;
  logic        o_led7;

  prbs_sync_checker dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_resync(i_resync), .i_clear_counters(i_clear_counters), .i_bit(i_bit),
    .o_state(o_state), .o_locked(o_locked), .o_err_count(o_err_count),
    .o_bit_count(o_bit_count), .o_lock_loss_cnt(o_lock_loss_cnt), .o_led(o_led)
  );

  prbs_sync_checker #(.N_PRBS(7), .TAP(6)) dut7 (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
    .i_resync(resync7), .i_clear_counters(clear7), .i_bit(i_bit7),
    .o_state(o_state7), .o_locked(o_locked7), .o_err_count(o_err_count7),
    .o_bit_count(o_bit_count7), .o_lock_loss_cnt(o_lock_loss_cnt7), .o_led(o_led7)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] obs_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [8:0]  g9;
  logic [6:0]  g7;
  int          locked_bits;

  // Next PRBS9 bit: x^9 + x^5 + 1
  task automatic gen9(output logic b);
    b  = g9[8] ^ g9[4];
    g9 = {g9[7:0], b};
  endtask

  // Next PRBS7 bit: x^7 + x^6 + 1
  task automatic gen7(output logic b);
    b  = g7[6] ^ g7[5];
    g7 = {g7[5:0], b};
  endtask

  // Drive one cycle; outputs are stable 1 time unit after the edge.
  task automatic clk_bit(input logic b, input logic en);
    i_bit    = b;
    i_enable = en;
    @(posedge i_clock);
    #1;
  endtask

  task automatic expect_obs(input string name, input logic [63:0] exp_v, input logic [63:0] obs_v);
    sb_q.push_back('{name: name, val: exp_v});
    obs_q.push_back(obs_v);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [63:0] o;
    i_reset = 1'b0; i_enable = 1'b0; i_resync = 1'b0; i_clear_counters = 1'b0;
    i_bit = 1'b0; i_bit7 = 1'b0; resync7 = 1'b0; clear7 = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    expect_obs("reset_state",     64'd0, 64'(o_state));
    expect_obs("reset_locked",    64'd0, 64'(o_locked));
    expect_obs("reset_err",       64'd0, 64'(o_err_count));
    expect_obs("reset_bits",      64'd0, 64'(o_bit_count));
    expect_obs("reset_loss",      64'd0, 64'(o_lock_loss_cnt));
    expect_obs("reset_led",       64'd0, 64'(o_led));
    expect_obs("reset7_state",    64'd0, 64'(o_state7));
    i_reset = 1'b1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  task automatic test_clean_lock();
    exp_t e;
    logic [63:0] o;
    logic b;
    int lock_at;
    g9 = 9'h1FF;
    lock_at = 0;
    sb_q.push_back('{name: "clean_lock_bit", val: 64'd137});
    for (int k = 1; k <= 400 && lock_at == 0; k++) begin
      gen9(b);
      clk_bit(b, 1'b1);
      if (o_locked) lock_at = k;
    end
    obs_q.push_back(64'(lock_at));
    locked_bits = 0;
    for (int k = 0; k < 1000; k++) begin
      gen9(b);
      clk_bit(b, 1'b1);
      locked_bits++;
    end
    expect_obs("clean_bits",  64'd1000, 64'(o_bit_count));
    expect_obs("clean_err",   64'd0,    64'(o_err_count));
    expect_obs("clean_led",   64'd1,    64'(o_led));
    expect_obs("clean_state", 64'd2,    64'(o_state));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  task automatic test_bit_errors();
    exp_t e;
    logic [63:0] o;
    logic b;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 10; k++) begin
        gen9(b); clk_bit(b, 1'b1); locked_bits++;
      end
      gen9(b); clk_bit(~b, 1'b1); locked_bits++;
    end
    expect_obs("flip3_err",   64'd3,    64'(o_err_count));
    expect_obs("flip3_led",   64'd0,    64'(o_led));
    expect_obs("flip3_state", 64'd2,    64'(o_state));
    expect_obs("flip3_bits",  64'd1033, 64'(o_bit_count));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  task automatic test_loss_relock();
    exp_t e;
    logic [63:0] o;
    logic b;
    int relock_at;
    // Align to the start of a LOCKED window.
    while ((locked_bits % 128) != 0) begin
      gen9(b); clk_bit(b, 1'b1); locked_bits++;
    end
    for (int k = 0; k < 20; k++) begin
      gen9(b); clk_bit(~b, 1'b1);
    end
    for (int k = 0; k < 107; k++) begin
      gen9(b); clk_bit(b, 1'b1);
    end
    expect_obs("loss_before_end", 64'd2, 64'(o_state));
    gen9(b); clk_bit(b, 1'b1);
    expect_obs("loss_state", 64'd0,  64'(o_state));
    expect_obs("loss_cnt",   64'd1,  64'(o_lock_loss_cnt));
    expect_obs("loss_err",   64'd23, 64'(o_err_count));
    relock_at = 0;
    sb_q.push_back('{name: "relock_bit", val: 64'd137});
    for (int k = 1; k <= 400 && relock_at == 0; k++) begin
      gen9(b); clk_bit(b, 1'b1);
      if (o_locked) relock_at = k;
    end
    obs_q.push_back(64'(relock_at));
    expect_obs("relock_err", 64'd23, 64'(o_err_count));
    expect_obs("relock_led", 64'd0,  64'(o_led));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    logic [63:0] o;
    logic b;
    for (int k = 0; k < 5; k++) begin
      gen9(b); clk_bit(b, 1'b1);
    end
    i_clear_counters = 1'b1;
    gen9(b); clk_bit(b, 1'b1);
    i_clear_counters = 1'b0;
    expect_obs("clear_err",   64'd0, 64'(o_err_count));
    expect_obs("clear_bits",  64'd0, 64'(o_bit_count));
    expect_obs("clear_loss",  64'd1, 64'(o_lock_loss_cnt));
    expect_obs("clear_state", 64'd2, 64'(o_state));
    expect_obs("clear_led",   64'd1, 64'(o_led));
    gen9(b); clk_bit(b, 1'b1);
    expect_obs("after_clear_bits", 64'd1, 64'(o_bit_count));
    i_resync = 1'b1; i_clear_counters = 1'b1;
    gen9(b); clk_bit(b, 1'b1);
    i_resync = 1'b0; i_clear_counters = 1'b0;
    expect_obs("resync_clear_state",  64'd0, 64'(o_state));
    expect_obs("resync_clear_locked", 64'd0, 64'(o_locked));
    expect_obs("resync_clear_loss",   64'd0, 64'(o_lock_loss_cnt));
    expect_obs("resync_clear_bits",   64'd0, 64'(o_bit_count));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [63:0] o;
    logic ever_locked;
    ever_locked = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      clk_bit(1'($urandom_range(0, 1)), 1'b1);
      if (o_locked !== 1'b0) ever_locked = 1'b1;
    end
    expect_obs("random_never_locked", 64'd0, 64'(ever_locked));
    expect_obs("random_err",          64'd0, 64'(o_err_count));
    expect_obs("random_bits",         64'd0, 64'(o_bit_count));
    expect_obs("random_loss",         64'd0, 64'(o_lock_loss_cnt));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  task automatic test_enable_toggle();
    exp_t e;
    logic [63:0] o;
    logic b;
    int n_en, lock_en, lock_clk;
    i_resync = 1'b1;
    clk_bit(1'b0, 1'b0);
    i_resync = 1'b0;
    n_en = 0; lock_en = 0; lock_clk = 0;
    sb_q.push_back('{name: "toggle_lock_enabled", val: 64'd137});
    sb_q.push_back('{name: "toggle_lock_clocks",  val: 64'd273});
    for (int c = 1; c <= 700 && lock_en == 0; c++) begin
      if ((c % 2) == 1) begin
        gen9(b); clk_bit(b, 1'b1); n_en++;
      end else begin
        clk_bit(1'($urandom_range(0, 1)), 1'b0);
      end
      if (o_locked) begin lock_en = n_en; lock_clk = c; end
    end
    obs_q.push_back(64'(lock_en));
    obs_q.push_back(64'(lock_clk));
    i_resync = 1'b1;
    clk_bit(1'b0, 1'b0);
    i_resync = 1'b0;
    for (int k = 0; k < 49; k++) begin
      gen9(b); clk_bit(b, 1'b1);
    end
    expect_obs("mid_verify_state", 64'd1, 64'(o_state));
    i_resync = 1'b1;
    gen9(b); clk_bit(b, 1'b1);
    i_resync = 1'b0;
    expect_obs("resync_verify_state", 64'd0, 64'(o_state));
    expect_obs("resync_verify_err",   64'd0, 64'(o_err_count));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  task automatic test_async_reset_prbs7();
    exp_t e;
    logic [63:0] o;
    logic b, b7;
    int lock_at, lock7_at;
    lock_at = 0;
    for (int k = 1; k <= 400 && lock_at == 0; k++) begin
      gen9(b); clk_bit(b, 1'b1);
      if (o_locked) lock_at = k;
    end
    expect_obs("prelock_locked", 64'd1, 64'(o_locked));
    for (int k = 0; k < 10; k++) begin
      gen9(b); clk_bit(b, 1'b1);
    end
    expect_obs("prereset_bits", 64'd10, 64'(o_bit_count));
    #2;
    i_reset = 1'b0;
    #1;
    expect_obs("areset_state",  64'd0, 64'(o_state));
    expect_obs("areset_locked", 64'd0, 64'(o_locked));
    expect_obs("areset_bits",   64'd0, 64'(o_bit_count));
    expect_obs("areset_led",    64'd0, 64'(o_led));
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;
    g7 = 7'h7F;
    lock7_at = 0;
    sb_q.push_back('{name: "prbs7_lock_bit", val: 64'd135});
    for (int k = 1; k <= 400 && lock7_at == 0; k++) begin
      gen7(b7);
      i_bit7 = b7;
      gen9(b); clk_bit(b, 1'b1);
      if (o_locked7) lock7_at = k;
    end
    obs_q.push_back(64'(lock7_at));
    expect_obs("prbs7_err", 64'd0, 64'(o_err_count7));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin failures++; $display("FAIL %s: got %0d expected %0d", e.name, o, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_bit_errors();
    test_loss_relock();
    test_clear();
    test_random();
    test_enable_toggle();
    test_async_reset_prbs7();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
